// File: rtl/freq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | freq_pkg : shared state type, default sizing and saturating-increment     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package freq_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_e;

  // 100000 cycles at 100 MHz makes the raw count read directly in kHz
  localparam int c_N_CH        = 4;
  localparam int c_CNT_W       = 32;
  localparam int c_GATE_CYCLES = 100000;

  // Counters up to 64 bits wide are carried through this 64-bit helper
  function automatic logic [63:0] sat_inc(input logic [63:0] val,
                                          input logic        inc,
                                          input logic [63:0] max_val);
    if (inc && (val != max_val)) begin
      return val + 64'd1;
    end
    return val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/freq_chan_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | freq_chan_counter : one channel - synchroniser, edge detect, sat counter  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module freq_chan_counter
  import freq_pkg::*;
#(
  parameter int CNT_W = c_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sensor_i,
  input  logic             clear_i,
  input  logic             count_en_i,
  output logic [CNT_W-1:0] next_cnt_o,
  output logic             sat_o
);

  logic [2:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sat_q;
  logic             w_edge;
  logic             w_at_max;

  // sync_q[1] is the first metastability-safe stage; sync_q[2] is its delay
  assign w_edge     = sync_q[1] & ~sync_q[2];
  assign w_at_max   = (cnt_q == {CNT_W{1'b1}});
  assign next_cnt_o = CNT_W'(sat_inc(64'(cnt_q), w_edge, 64'({CNT_W{1'b1}})));
  assign sat_o      = sat_q | (w_edge & w_at_max);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], sensor_i};
      if (clear_i) begin
        cnt_q <= '0;
        sat_q <= 1'b0;
      end else if (count_en_i) begin
        cnt_q <= next_cnt_o;
        sat_q <= sat_o;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/freq_counter_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | freq_counter_multi : gated-window multi-channel frequency counter         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module freq_counter_multi
  import freq_pkg::*;
#(
  parameter int N_CH        = c_N_CH,
  parameter int CNT_W       = c_CNT_W,
  parameter int GATE_CYCLES = c_GATE_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       sensor_in_i,
  input  logic                  start_i,
  input  logic                  continuous_i,
  output logic [N_CH*CNT_W-1:0] freq_out_o,
  output logic [N_CH-1:0]       freq_sat_o,
  output logic                  freq_valid_o,
  output logic                  busy_o
);

  localparam int             WIN_W      = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [WIN_W-1:0] c_WIN_LAST = WIN_W'(GATE_CYCLES - 1);

  state_e                state_q, state_d;
  logic [WIN_W-1:0]      win_q;
  logic [N_CH*CNT_W-1:0] freq_out_q;
  logic [N_CH-1:0]       freq_sat_q;
  logic                  freq_valid_q;

  logic [N_CH*CNT_W-1:0] w_next_cnt;
  logic [N_CH-1:0]       w_sat;
  logic                  w_counting;
  logic                  w_last;
  logic                  w_clear;

  assign w_counting = (state_q == ST_COUNT);
  assign w_last     = w_counting && (win_q == c_WIN_LAST);
  // Clearing on the last cycle lets a back-to-back window start with no gap
  assign w_clear    = !w_counting || w_last;

  generate
    for (genvar g = 0; g < N_CH; g++) begin : g_chan
      freq_chan_counter #(
        .CNT_W(CNT_W)
      ) u_chan (
        .clk        (clk),
        .rst        (rst),
        .sensor_i   (sensor_in_i[g]),
        .clear_i    (w_clear),
        .count_en_i (w_counting),
        .next_cnt_o (w_next_cnt[g*CNT_W +: CNT_W]),
        .sat_o      (w_sat[g])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i || continuous_i) state_d = ST_COUNT;
      ST_COUNT: if (w_last && !continuous_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q        <= '0;
      freq_out_q   <= '0;
      freq_sat_q   <= '0;
      freq_valid_q <= 1'b0;
    end else begin
      freq_valid_q <= w_last;
      if (w_last) begin
        freq_out_q <= w_next_cnt;
        freq_sat_q <= w_sat;
      end
      if (w_clear) begin
        win_q <= '0;
      end else begin
        win_q <= win_q + WIN_W'(1);
      end
    end
  end

  assign freq_out_o   = freq_out_q;
  assign freq_sat_o   = freq_sat_q;
  assign freq_valid_o = freq_valid_q;
  assign busy_o       = w_counting;

endmodule
`default_nettype wire

// File: tb/tb_freq_counter_multi.sv
`default_nettype none
// Bench for freq_counter_multi: directed vector table, corner sequences and a
// randomized phase checked against a window-level edge-counting model.
module tb_freq_counter_multi;

  localparam int G = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic [1:0] sensor = 2'b00;

  logic [15:0] fo;
  logic [1:0]  fs;
  logic        fv, fb;
  logic [3:0]  fo_s;
  logic [1:0]  fs_s;
  logic        fv_s, fb_s;

  always #5 clk = ~clk;

  freq_counter_multi #(.N_CH(2), .CNT_W(8), .GATE_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .sensor_in_i(sensor), .start_i(start), .continuous_i(cont),
    .freq_out_o(fo), .freq_sat_o(fs), .freq_valid_o(fv), .busy_o(fb));

  freq_counter_multi #(.N_CH(2), .CNT_W(2), .GATE_CYCLES(G)) dut_s (
    .clk(clk), .rst(rst), .sensor_in_i(sensor), .start_i(start), .continuous_i(cont),
    .freq_out_o(fo_s), .freq_sat_o(fs_s), .freq_valid_o(fv_s), .busy_o(fb_s));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Reference model: a window closes 16 cycles after it opens and reports the
  // number of sampled rising transitions whose detection fell inside it.
  int          cyc = 0;
  logic [1:0]  hist [64] = '{default: 2'b00};
  bit          m_busy = 1'b0;
  bit          m_valid = 1'b0;
  int          m_end = 0;
  int          n;
  logic [15:0] m_fo = '0;
  logic [3:0]  m_fo_s = '0;
  logic [1:0]  m_fs = '0;
  logic [1:0]  m_fs_s = '0;

  always @(posedge clk) begin
    hist[cyc % 64] = rst ? 2'b00 : sensor;
    m_valid = 1'b0;
    if (rst) begin
      m_busy = 1'b0;
      m_fo = '0; m_fo_s = '0; m_fs = '0; m_fs_s = '0;
    end else if (!m_busy) begin
      if (start || cont) begin
        m_busy = 1'b1;
        m_end  = cyc + G;
      end
    end else if (cyc == m_end) begin
      for (int ch = 0; ch < 2; ch++) begin
        n = 0;
        for (int k = cyc - G - 1; k <= cyc - 2; k++)
          if (hist[k % 64][ch] && !hist[(k - 1) % 64][ch]) n++;
        m_fo[ch*8 +: 8]   = (n > 255) ? 8'hFF : 8'(n);
        m_fs[ch]          = (n > 255);
        m_fo_s[ch*2 +: 2] = (n > 3) ? 2'd3 : 2'(n);
        m_fs_s[ch]        = (n > 3);
      end
      m_valid = 1'b1;
      if (cont) m_end = cyc + G;
      else      m_busy = 1'b0;
    end
    cyc++;
    #1;
    chk("model_w8", {fv, fb, fs, fo}, {m_valid, m_busy, m_fs, m_fo});
    chk("model_w2", {fv_s, fb_s, fs_s, fo_s}, {m_valid, m_busy, m_fs_s, m_fo_s});
  end

  // Stimulus: per[ch] is a free-running period (0 = manual level from man)
  bit         rnd = 1'b0;
  int         per [2] = '{0, 0};
  logic [1:0] man = 2'b00;

  task automatic tick();
    @(negedge clk);
    for (int ch = 0; ch < 2; ch++) begin
      if (rnd)               sensor[ch] = 1'($urandom);
      else if (per[ch] == 0) sensor[ch] = man[ch];
      else                   sensor[ch] = 1'((cyc / (per[ch] / 2)) % 2);
    end
  endtask

  task automatic wait_next(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!fv && cnt < 40);
    if (!fv) chk("valid_timeout", {63'd0, fv}, 64'd1);
  endtask

  task automatic run_single(output int lat, output int bc);
    tick(); start = 1'b1; tick(); start = 1'b0;
    lat = 0; bc = 0;
    while (!fv && lat < 40) begin
      if (fb) bc++;
      tick();
      lat++;
    end
  endtask

  typedef struct {
    int         p0;
    int         p1;
    logic [7:0] e0;
    logic [7:0] e1;
    logic [1:0] s0;
    logic [1:0] s1;
    logic [1:0] ssat;
  } vec_t;

  vec_t vt [5];

  initial begin
    int lat, bc, w;
    bit seen;
    vt[0] = '{2,  4,  8'd8, 8'd4, 2'd3, 2'd3, 2'b11};
    vt[1] = '{4,  8,  8'd4, 8'd2, 2'd3, 2'd2, 2'b01};
    vt[2] = '{8,  16, 8'd2, 8'd1, 2'd2, 2'd1, 2'b00};
    vt[3] = '{2,  0,  8'd8, 8'd0, 2'd3, 2'd0, 2'b01};
    vt[4] = '{16, 2,  8'd1, 8'd8, 2'd1, 2'd3, 2'b10};

    repeat (3) tick();
    rst = 1'b0;

    seen = 1'b0;
    repeat (40) begin
      tick();
      if (fv) seen = 1'b1;
    end
    chk("idle_no_valid", {63'd0, seen}, 64'd0);
    chk("idle_out", {fs, fo}, 64'd0);
    chk("idle_busy", {63'd0, fb}, 64'd0);

    for (int i = 0; i < 5; i++) begin
      per[0] = vt[i].p0;
      per[1] = vt[i].p1;
      man    = 2'b00;
      repeat (20) tick();
      run_single(lat, bc);
      chk("vec_latency", lat, 16);
      chk("vec_busy_len", bc, 16);
      chk("vec_busy_after", {63'd0, fb}, 64'd0);
      chk("vec_ch0", fo[7:0], vt[i].e0);
      chk("vec_ch1", fo[15:8], vt[i].e1);
      chk("vec_sat_w8", fs, 2'b00);
      chk("vec_small", {fs_s, fo_s}, {vt[i].ssat, vt[i].s1, vt[i].s0});
    end

    per[0] = 2; per[1] = 4;
    repeat (20) tick();
    tick(); cont = 1'b1; tick();
    wait_next(w);
    chk("cont_w1_len", w, 16);
    chk("cont_w1_ch0", fo[7:0], 8'd8);
    wait_next(w);
    chk("cont_w2_len", w, 16);
    chk("cont_w2_ch0", fo[7:0], 8'd8);
    repeat (8) tick();
    cont = 1'b0;
    wait_next(w);
    chk("cont_w3_len", w, 8);
    chk("cont_w3_ch0", fo[7:0], 8'd8);
    chk("cont_w3_busy", {63'd0, fb}, 64'd0);
    tick();
    chk("cont_pulse_once", {62'd0, fv, fb}, 64'd0);

    per[0] = 2; per[1] = 0; man = 2'b00;
    repeat (5) tick();
    tick(); start = 1'b1; tick(); start = 1'b0;
    repeat (12) tick();
    man[1] = 1'b1;
    tick();
    wait_next(w);
    chk("lastcyc_len", w, 3);
    chk("lastcyc_ch1", fo[15:8], 8'd1);
    man[1] = 1'b0;
    repeat (5) tick();
    tick(); cont = 1'b1; tick();
    repeat (13) tick();
    man[1] = 1'b1;
    tick();
    wait_next(w);
    chk("late_w1_len", w, 2);
    chk("late_w1_ch1", fo[15:8], 8'd0);
    cont = 1'b0;
    wait_next(w);
    chk("late_w2_len", w, 16);
    chk("late_w2_ch1", fo[15:8], 8'd1);
    man[1] = 1'b0;
    repeat (5) tick();

    tick(); start = 1'b1; tick(); start = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_outputs", {fv, fb, fs, fo}, 64'd0);
    seen = 1'b0;
    repeat (30) begin
      tick();
      if (fv) seen = 1'b1;
    end
    chk("rst_no_valid", {63'd0, seen}, 64'd0);

    tick(); start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_next(w);
    chk("restart_ignored_len", w, 11);
    tick();
    chk("restart_idle", {63'd0, fb}, 64'd0);

    rnd = 1'b1;
    for (int i = 0; i < 900; i++) begin
      tick();
      start = (($urandom % 6) == 0);
      if (($urandom % 30) == 0) cont = ~cont;
      rst = (($urandom % 150) == 0);
    end
    rnd = 1'b0; rst = 1'b0; start = 1'b0; cont = 1'b0;
    repeat (40) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
